// File: rtl/aha_clk_switch_pkg.sv
// Shared types and helpers for the clock-source switch sequencer.
package aha_clk_switch_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDesel   = 2'd1,
    StSel     = 2'd2,
    StRestore = 2'd3
  } state_e;

  localparam int unsigned MaxClks        = 16;
  localparam int unsigned DefaultTimeout = 1023;

  function automatic logic [MaxClks-1:0] onehot(input logic [3:0] idx);
    onehot = MaxClks'(1) << idx;
  endfunction

endpackage

// File: rtl/aha_sync_2ff.sv
// Two-flop synchronizer, one chain per bit, asynchronously reset to zero.
module aha_sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/aha_clock_switch_ctrl.sv
// Break-before-make sequencer driving a bank of glitch-free clock switch slices,
// with per-phase timeout and fallback to the previously committed source.
module aha_clock_switch_ctrl
  import aha_clk_switch_pkg::*;
#(
  parameter int unsigned NUM_CLKS       = 4,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned DEFAULT_SEL    = 0,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                REQ_VALID,
  input  logic [SEL_W-1:0]    REQ_IDX,
  output logic                REQ_READY,
  output logic [NUM_CLKS-1:0] SELECT_REQ,
  input  logic [NUM_CLKS-1:0] SELECT_ACK,
  output logic [SEL_W-1:0]    CUR_SEL,
  output logic                BUSY,
  output logic                DONE,
  output logic                REJECT,
  output logic                TIMEOUT_ERR,
  input  logic                ERR_CLR
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_CLKS-1:0] DefaultOh  = NUM_CLKS'(onehot(4'(DEFAULT_SEL)));
  localparam logic [SEL_W-1:0]    DefaultSel = SEL_W'(DEFAULT_SEL);

  state_e              state_q;
  logic [NUM_CLKS-1:0] select_req_q;
  logic [SEL_W-1:0]    cur_sel_q, target_q, prev_q;
  logic [TimerW-1:0]   timer_q;
  logic                done_q, reject_q, err_q;

  logic [NUM_CLKS-1:0] ack_s;
  logic [NUM_CLKS-1:0] oh_target, oh_prev;
  logic                idx_oob, ack_target, ack_prev, acks_low, tmo;

  aha_sync_2ff #(
    .Width (NUM_CLKS)
  ) u_ack_sync (
    .clk_i  (CLK),
    .rst_ni (RESETn),
    .d_i    (SELECT_ACK),
    .q_o    (ack_s)
  );

  assign oh_target  = NUM_CLKS'(onehot(4'(target_q)));
  assign oh_prev    = NUM_CLKS'(onehot(4'(prev_q)));
  assign idx_oob    = {1'b0, REQ_IDX} >= (SEL_W + 1)'(NUM_CLKS);
  assign ack_target = |(ack_s & oh_target);
  assign ack_prev   = |(ack_s & oh_prev);
  assign acks_low   = ~|ack_s;
  // Exit conditions are tested before tmo, so a late ack still wins.
  assign tmo        = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= StIdle;
      select_req_q <= DefaultOh;
      cur_sel_q    <= DefaultSel;
      target_q     <= DefaultSel;
      prev_q       <= DefaultSel;
      timer_q      <= '0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      if (ERR_CLR) err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (REQ_VALID) begin
            if (idx_oob) begin
              reject_q <= 1'b1;
            end else if (REQ_IDX == cur_sel_q) begin
              done_q <= 1'b1;
            end else begin
              target_q     <= REQ_IDX;
              prev_q       <= cur_sel_q;
              select_req_q <= '0;
              state_q      <= StDesel;
            end
          end
        end
        StDesel: begin
          if (acks_low || tmo) begin
            if (!acks_low) err_q <= 1'b1;
            select_req_q <= oh_target;
            timer_q      <= '0;
            state_q      <= StSel;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StSel: begin
          if (ack_target) begin
            cur_sel_q <= target_q;
            done_q    <= 1'b1;
            timer_q   <= '0;
            state_q   <= StIdle;
          end else if (tmo) begin
            err_q        <= 1'b1;
            select_req_q <= oh_prev;
            timer_q      <= '0;
            state_q      <= StRestore;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StRestore: begin
          if (ack_prev || tmo) begin
            if (!ack_prev) err_q <= 1'b1;
            done_q  <= 1'b1;
            timer_q <= '0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign REQ_READY   = (state_q == StIdle);
  assign BUSY        = (state_q != StIdle);
  assign SELECT_REQ  = select_req_q;
  assign CUR_SEL     = cur_sel_q;
  assign DONE        = done_q;
  assign REJECT      = reject_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_aha_clock_switch_ctrl.sv
// Scoreboarded bench: directed requests queue expected DONE/REJECT outcomes, a monitor checks them.
module tb_aha_clock_switch_ctrl;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic [1:0] REQ_IDX = '0;
  logic       REQ_READY;
  logic [2:0] SELECT_REQ;
  logic [2:0] SELECT_ACK;
  logic [1:0] CUR_SEL;
  logic       BUSY, DONE, REJECT, TIMEOUT_ERR;
  logic       ERR_CLR = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rej;
    logic [1:0] cur;
    logic       err;
    logic [2:0] sel;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  aha_clock_switch_ctrl #(
    .NUM_CLKS       (3),
    .SEL_W          (2),
    .DEFAULT_SEL    (0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .REQ_VALID   (REQ_VALID),
    .REQ_IDX     (REQ_IDX),
    .REQ_READY   (REQ_READY),
    .SELECT_REQ  (SELECT_REQ),
    .SELECT_ACK  (SELECT_ACK),
    .CUR_SEL     (CUR_SEL),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .REJECT      (REJECT),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .ERR_CLR     (ERR_CLR)
  );

  always #5 CLK = ~CLK;

  // Slice model: ack follows its request 3 cycles later unless the source is dead.
  logic [2:0][2:0] sh = '0;
  logic [2:0]      dead = '0;

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) sh[i] <= {sh[i][1:0], SELECT_REQ[i]};
  end

  always_comb begin
    SELECT_ACK = '0;
    for (int i = 0; i < 3; i++) SELECT_ACK[i] = sh[i][2] & ~dead[i];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per DONE/REJECT pulse; also polices one-hot select.
  always @(negedge CLK) begin
    if (RESETn) begin
      if (DONE || REJECT) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: done=%0b reject=%0b, expected no pulse", DONE, REJECT);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_kind", {30'd0, REJECT, DONE}, mon_e.rej ? 32'd2 : 32'd1);
          chk("sb_cur_sel", CUR_SEL, mon_e.cur);
          chk("sb_timeout_err", TIMEOUT_ERR, mon_e.err);
          chk("sb_select_req", SELECT_REQ, mon_e.sel);
        end
      end
      chk("onehot_or_zero", ($countones(SELECT_REQ) <= 1), 1);
    end
  end

  task automatic push(input bit rej, input logic [1:0] cur, input logic err,
                      input logic [2:0] sel);
    exp_t e;
    e.rej = rej; e.cur = cur; e.err = err; e.sel = sel;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] idx);
    int n = 0;
    REQ_VALID = 1'b1;
    REQ_IDX   = idx;
    while (!REQ_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("req_ready_bound", REQ_READY, 1);
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_reached", BUSY, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("sb_drained", sb_q.size(), 0);
  endtask

  // Switch 2 -> 1 with source 1 dead; optionally raise ERR_CLR on the exact timeout edge.
  task automatic dead_switch(input bit coincident_clr);
    int n = 0;
    push(1'b0, 2'd2, 1'b1, 3'b100);
    send(2'd1);
    while (SELECT_REQ !== 3'b010 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("dead_sel_entry", SELECT_REQ, 3'b010);
    repeat (15) @(negedge CLK);
    chk("dead_pre_timeout_sel", SELECT_REQ, 3'b010);
    chk("dead_pre_timeout_err", TIMEOUT_ERR, 0);
    if (coincident_clr) ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    chk("dead_restore_sel", SELECT_REQ, 3'b100);
    chk("dead_timeout_err", TIMEOUT_ERR, 1);
    wait_idle();
    drain();
    chk("dead_cur_sel", CUR_SEL, 2);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    chk("rst_select_req", SELECT_REQ, 3'b001);
    chk("rst_cur_sel", CUR_SEL, 0);
    chk("rst_ready", REQ_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_pulses", {DONE, REJECT, TIMEOUT_ERR}, 0);
    RESETn = 1'b1;
    repeat (5) @(negedge CLK);
    chk("rst_ack_s0", dut.ack_s[0], 1);

    // Normal switch 0 -> 2: must hold all-zero until the old ack drops.
    push(1'b0, 2'd2, 1'b0, 3'b100);
    send(2'd2);
    chk("sw_desel_zero", SELECT_REQ, 3'b000);
    chk("sw_busy", {REQ_READY, BUSY}, 2'b01);
    @(negedge CLK);
    chk("sw_desel_held", SELECT_REQ, 3'b000);
    wait_idle();
    drain();
    chk("sw_cur_sel", CUR_SEL, 2);

    // Same index: DONE the cycle after the handshake, no select change.
    push(1'b0, 2'd2, 1'b0, 3'b100);
    send(2'd2);
    chk("same_done", DONE, 1);
    chk("same_busy", BUSY, 0);
    chk("same_select", SELECT_REQ, 3'b100);

    // Out-of-range index with three sources.
    push(1'b1, 2'd2, 1'b0, 3'b100);
    send(2'd3);
    chk("bad_reject", REJECT, 1);
    chk("bad_busy", BUSY, 0);
    chk("bad_select", SELECT_REQ, 3'b100);
    drain();

    // Dead target, then isolated clear, then clear coincident with timeout.
    dead[1] = 1'b1;
    dead_switch(1'b0);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    chk("err_clr_isolated", TIMEOUT_ERR, 0);
    dead_switch(1'b1);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    chk("err_clr_after", TIMEOUT_ERR, 0);
    dead[1] = 1'b0;

    // Request held while busy is taken only once back in IDLE.
    push(1'b0, 2'd0, 1'b0, 3'b001);
    send(2'd0);
    REQ_VALID = 1'b1;
    REQ_IDX   = 2'd2;
    push(1'b0, 2'd2, 1'b0, 3'b100);
    n = 0;
    while (BUSY && n < 100) begin
      chk("ready_low_busy", REQ_READY, 0);
      @(negedge CLK);
      n++;
    end
    chk("held_idle_done", DONE, 1);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    chk("held_accepted", {BUSY, SELECT_REQ}, 4'b1000);
    wait_idle();
    drain();

    // Asynchronous reset while in SEL of a 2 -> 1 switch.
    send(2'd1);
    n = 0;
    while (SELECT_REQ !== 3'b010 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("midrst_in_sel", SELECT_REQ, 3'b010);
    RESETn = 1'b0;
    #1;
    chk("midrst_select", SELECT_REQ, 3'b001);
    chk("midrst_busy_ready", {BUSY, REQ_READY}, 2'b01);
    chk("midrst_cur_sel", CUR_SEL, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (8) @(negedge CLK);
    push(1'b0, 2'd2, 1'b0, 3'b100);
    send(2'd2);
    wait_idle();
    drain();
    chk("post_rst_cur_sel", CUR_SEL, 2);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
